game_flow_ctrl: RTL and testbench



---
 rtl/game_flow_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl
//   Top-level game sequencer for Snake. Walks START -> PLAY -> DIE -> END,
//   paces snake movement with a level-dependent move_tick, raises the level
//   as apples are eaten and blinks the snake before the game-over screen.
//
// Ports
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   key_start    in   single-cycle start/continue pulse
//   hit_wall     in   head-on-wall collision flag
//   hit_body     in   head-on-body collision flag
//   add_cube     in   single-cycle pulse when an apple is eaten
//   game_status  out  0=START 1=PLAY 2=DIE 3=END (registered)
//   move_tick    out  one-cycle pulse per snake step (registered)
//   flash_on     out  snake visible when 1 (registered)
//   level        out  current speed level 0..LEVEL_MAX (registered)
module game_flow_ctrl #(
  parameter int unsigned STEP_BASE   = 12_500_000,
  parameter int unsigned STEP_DEC    = 1_000_000,
  parameter int unsigned LEVEL_MAX   = 7,
  parameter int unsigned LEVEL_PTS   = 5,
  parameter int unsigned FLASH_TICKS = 6_250_000,
  parameter int unsigned FLASH_COUNT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_start,
  input  logic       hit_wall,
  input  logic       hit_body,
  input  logic       add_cube,
  output logic [1:0] game_status,
  output logic       move_tick,
  output logic       flash_on,
  output logic [2:0] level
);

  localparam int unsigned STEP_W  = (STEP_BASE > 1) ? $clog2(STEP_BASE) : 1;
  localparam int unsigned FLASH_W = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;
  localparam int unsigned TOG_W   = $clog2(2 * FLASH_COUNT);
  localparam int unsigned APPLE_W = (LEVEL_PTS > 1) ? $clog2(LEVEL_PTS) : 1;

  localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_TICKS - 1);
  localparam logic [TOG_W-1:0]   TOG_LAST   = TOG_W'(2 * FLASH_COUNT - 1);
  localparam logic [APPLE_W-1:0] APPLE_LAST = APPLE_W'(LEVEL_PTS - 1);
  localparam logic [2:0]         LEVEL_TOP  = 3'(LEVEL_MAX);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_PLAY  = 2'd1,
    ST_DIE   = 2'd2,
    ST_END   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [STEP_W-1:0]  step_cnt_q, step_cnt_d;
  logic [STEP_W-1:0]  step_term_q, step_term_d;
  logic [APPLE_W-1:0] apple_q, apple_d;
  logic [2:0]         level_q, level_d;
  logic [FLASH_W-1:0] flash_tmr_q, flash_tmr_d;
  logic [TOG_W-1:0]   tog_q, tog_d;
  logic               flash_q, flash_d;
  logic               move_tick_q, move_tick_d;
  logic               collide;

  // Terminal count of the step counter for a given level. The product is
  // bounded by LEVEL_MAX*STEP_DEC < STEP_BASE, so the result always fits.
  function automatic logic [STEP_W-1:0] step_term(input logic [2:0] lvl);
    int unsigned period;
    period = STEP_BASE - (32'(lvl) * STEP_DEC);
    return STEP_W'(period - 1);
  endfunction

  assign collide = hit_wall | hit_body;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_START;
      step_cnt_q  <= '0;
      step_term_q <= step_term(3'd0);
      apple_q     <= '0;
      level_q     <= '0;
      flash_tmr_q <= '0;
      tog_q       <= '0;
      flash_q     <= 1'b1;
      move_tick_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_cnt_q  <= step_cnt_d;
      step_term_q <= step_term_d;
      apple_q     <= apple_d;
      level_q     <= level_d;
      flash_tmr_q <= flash_tmr_d;
      tog_q       <= tog_d;
      flash_q     <= flash_d;
      move_tick_q <= move_tick_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    step_cnt_d  = step_cnt_q;
    step_term_d = step_term_q;
    apple_d     = apple_q;
    level_d     = level_q;
    flash_tmr_d = flash_tmr_q;
    tog_d       = tog_q;
    flash_d     = 1'b1;
    move_tick_d = 1'b0;

    unique case (state_q)
      ST_START: begin
        if (key_start) begin
          state_d     = ST_PLAY;
          level_d     = '0;
          apple_d     = '0;
          step_cnt_d  = '0;
          step_term_d = step_term(3'd0);
        end
      end

      ST_PLAY: begin
        if (collide) begin
          // Collision wins over a same-cycle apple and suppresses the tick
          // so move_tick never shows up in the first DIE cycle.
          state_d     = ST_DIE;
          flash_tmr_d = '0;
          tog_d       = '0;
        end else begin
          if (step_cnt_q == step_term_q) begin
            move_tick_d = 1'b1;
            step_cnt_d  = '0;
            // The period is latched only here, so a level change never
            // shortens the interval already in progress.
            step_term_d = step_term(level_q);
          end else begin
            step_cnt_d = step_cnt_q + 1'b1;
          end

          if (add_cube) begin
            if (apple_q == APPLE_LAST) begin
              apple_d = '0;
              if (level_q < LEVEL_TOP) begin
                level_d = level_q + 1'b1;
              end
            end else begin
              apple_d = apple_q + 1'b1;
            end
          end
        end
      end

      ST_DIE: begin
        flash_d = flash_q;
        if (flash_tmr_q == FLASH_LAST) begin
          flash_tmr_d = '0;
          if (tog_q == TOG_LAST) begin
            // Last toggle lands on END with the snake visible.
            state_d = ST_END;
            flash_d = 1'b1;
            tog_d   = '0;
          end else begin
            flash_d = ~flash_q;
            tog_d   = tog_q + 1'b1;
          end
        end else begin
          flash_tmr_d = flash_tmr_q + 1'b1;
        end
      end

      ST_END: begin
        if (key_start) begin
          state_d = ST_START;
        end
      end

      default: state_d = ST_START;
    endcase
  end

  assign game_status = state_q;
  assign move_tick   = move_tick_q;
  assign flash_on    = flash_q;
  assign level       = level_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl
//   Self-checking bench for game_flow_ctrl with small timing parameters.
//   Expected outputs are queued against the cycle in which they must appear
//   and compared at the falling edge of that cycle.
module tb_game_flow_ctrl;

  localparam int unsigned STEP_BASE   = 20;
  localparam int unsigned STEP_DEC    = 2;
  localparam int unsigned LEVEL_MAX   = 3;
  localparam int unsigned LEVEL_PTS   = 2;
  localparam int unsigned FLASH_TICKS = 4;
  localparam int unsigned FLASH_COUNT = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       key_start = 1'b0;
  logic       hit_wall = 1'b0;
  logic       hit_body = 1'b0;
  logic       add_cube = 1'b0;
  logic [1:0] game_status;
  logic       move_tick;
  logic       flash_on;
  logic [2:0] level;

  game_flow_ctrl #(
    .STEP_BASE  (STEP_BASE),
    .STEP_DEC   (STEP_DEC),
    .LEVEL_MAX  (LEVEL_MAX),
    .LEVEL_PTS  (LEVEL_PTS),
    .FLASH_TICKS(FLASH_TICKS),
    .FLASH_COUNT(FLASH_COUNT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_start  (key_start),
    .hit_wall   (hit_wall),
    .hit_body   (hit_body),
    .add_cube   (add_cube),
    .game_status(game_status),
    .move_tick  (move_tick),
    .flash_on   (flash_on),
    .level      (level)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned at;
    string       name;
    logic [1:0]  st;
    logic        mt;
    logic        fl;
    logic [2:0]  lv;
  } exp_t;

  typedef struct {
    logic       ks;
    logic       hw;
    logic       hb;
    logic       ac;
    logic [1:0] st;
    logic [2:0] lv;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[13];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic cmp(input string name, input logic [1:0] st, input logic mt,
                     input logic fl, input logic [2:0] lv);
    n_cmp++;
    if (game_status !== st || move_tick !== mt || flash_on !== fl || level !== lv) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got status=%0d tick=%b flash=%b level=%0d, expected status=%0d tick=%b flash=%b level=%0d",
               name, cyc, game_status, move_tick, flash_on, level, st, mt, fl, lv);
    end
  endtask

  task automatic expect_at(input int unsigned at, input string name, input logic [1:0] st,
                           input logic mt, input logic fl, input logic [2:0] lv);
    exp_t e;
    e.at = at; e.name = name; e.st = st; e.mt = mt; e.fl = fl; e.lv = lv;
    sb.push_back(e);
  endtask

  // Compare every queued expectation that falls due in the current cycle.
  task automatic check_due();
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        cmp(sb[i].name, sb[i].st, sb[i].mt, sb[i].fl, sb[i].lv);
        sb.delete(i);
      end else if (sb[i].at < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s: expectation for cycle %0d was never compared", sb[i].name, sb[i].at);
        sb.delete(i);
      end
    end
  endtask

  // One cycle: at the falling edge, check due outputs, then drive inputs
  // that are held for the rest of this cycle.
  task automatic step(input logic ks, input logic hw, input logic hb, input logic ac);
    @(negedge clk);
    check_due();
    key_start = ks;
    hit_wall  = hw;
    hit_body  = hb;
    add_cube  = ac;
  endtask

  task automatic at_cycle(input int unsigned at, input logic ks, input logic hw,
                          input logic hb, input logic ac);
    while (cyc + 1 < at) step(1'b0, 1'b0, 1'b0, 1'b0);
    step(ks, hw, hb, ac);
  endtask

  // Flash level in the k-th cycle of DIE (k=1 is the entry cycle).
  function automatic logic die_flash(input int k);
    return (((k - 1) / FLASH_TICKS) % 2) == 0;
  endfunction

  initial begin
    int unsigned n, m, d, r;
    logic        t;
    logic [2:0]  lv;

    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd3}; // START ignores hit_wall
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 3'd3}; // START ignores hit_body
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 3'd3}; // START ignores add_cube
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 3'd3};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 3'd0}; // enter PLAY, level clears
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 3'd0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 3'd0}; // key_start ignored in PLAY
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 3'd0}; // apple 1
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 3'd1}; // level 1
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 3'd1}; // apple 1 again
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 3'd1}; // collision beats apple
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 3'd1}; // key_start ignored in DIE
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 3'd1};

    // Reset behaviour.
    #1 rst_n = 1'b0;
    #1 cmp("reset_async", 2'd0, 1'b0, 1'b1, 3'd0);
    repeat (2) @(negedge clk);
    cmp("reset_held", 2'd0, 1'b0, 1'b1, 3'd0);
    rst_n = 1'b1;
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    cmp("start_idle", 2'd0, 1'b0, 1'b1, 3'd0);

    // Game 1: tick pacing, levelling and saturation.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    n = cyc;
    for (int k = 1; k <= 150; k++) begin
      t = (k == 21) || (k == 41) || (k == 61) || (k == 81) || (k == 99) ||
          (k == 117) || (k == 131) || (k == 145);
      lv = (k < 65) ? 3'd0 : (k < 103) ? 3'd1 : (k < 107) ? 3'd2 : 3'd3;
      expect_at(n + k, "g1_play", 2'd1, t, 1'b1, lv);
    end
    at_cycle(n + 62, 1'b0, 1'b0, 1'b0, 1'b1);
    at_cycle(n + 64, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int j = 0; j < 6; j++) begin
      at_cycle(n + 100 + 2 * j, 1'b0, 1'b0, 1'b0, 1'b1);
    end

    // Wall hit at level 3, blink sequence, END holds level.
    at_cycle(n + 152, 1'b0, 1'b1, 1'b0, 1'b0);
    m = cyc;
    for (int k = 1; k <= 21; k++) begin
      if (k <= 16) expect_at(m + k, "g1_die", 2'd2, 1'b0, die_flash(k), 3'd3);
      else         expect_at(m + k, "g1_end", 2'd3, 1'b0, 1'b1, 3'd3);
    end
    at_cycle(m + 3, 1'b0, 1'b0, 1'b1, 1'b1);
    at_cycle(m + 6, 1'b1, 1'b0, 1'b0, 1'b0);
    at_cycle(m + 21, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_at(m + 22, "end_to_start", 2'd0, 1'b0, 1'b1, 3'd3);

    // Table of single-cycle vectors; each result is due one cycle later.
    d = 0;
    for (int i = 0; i < 13; i++) begin
      step(vecs[i].ks, vecs[i].hw, vecs[i].hb, vecs[i].ac);
      expect_at(cyc + 1, $sformatf("vec%0d", i), vecs[i].st, 1'b0, 1'b1, vecs[i].lv);
      if (i == 10) d = cyc;
    end

    // Rest of that DIE at level 1, END, START, then a fresh PLAY at level 0.
    for (int k = 3; k <= 20; k++) begin
      if (k <= 16)      expect_at(d + k, "g2_die", 2'd2, 1'b0, die_flash(k), 3'd1);
      else if (k <= 19) expect_at(d + k, "g2_end", 2'd3, 1'b0, 1'b1, 3'd1);
      else              expect_at(d + k, "g2_start", 2'd0, 1'b0, 1'b1, 3'd1);
    end
    at_cycle(d + 19, 1'b1, 1'b0, 1'b0, 1'b0);
    at_cycle(d + 22, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 23; k <= 55; k++) begin
      lv = (k < 53) ? 3'd0 : 3'd1;
      expect_at(d + k, "g3_play", 2'd1, k == 43, 1'b1, lv);
    end
    at_cycle(d + 50, 1'b0, 1'b0, 1'b0, 1'b1);
    at_cycle(d + 52, 1'b0, 1'b0, 1'b0, 1'b1);
    at_cycle(d + 56, 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset between clock edges in the middle of PLAY.
    #2 rst_n = 1'b0;
    #1 cmp("reset_mid_play", 2'd0, 1'b0, 1'b1, 3'd0);
    @(posedge clk);
    #1 cmp("reset_over_edge", 2'd0, 1'b0, 1'b1, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    r = cyc;
    for (int k = 1; k <= 25; k++) begin
      expect_at(r + k, "post_reset_start", 2'd0, 1'b0, 1'b1, 3'd0);
    end
    at_cycle(r + 26, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 27; k <= 47; k++) begin
      expect_at(r + k, "post_reset_play", 2'd1, k == 47, 1'b1, 3'd0);
    end
    at_cycle(r + 50, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);

    while (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: expectation for cycle %0d left unchecked", sb[0].name, sb[0].at);
      void'(sb.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
